rx_commit_fifo: RTL and testbench
=================================

Name: rx_commit_fifo

Overview:
- Parametrised payload buffer between the demapper and the UART TX path of the receiver.
- Holds each frame's payload tentatively until the demapper's CRC verdict arrives.
  - Good frame: commits the payload.
  - CRC error with ARQ enabled: rolls back and discards the whole frame.
- Replaces the reset-the-FIFO-on-error scheme. Only verified bytes ever reach the UART, and previously committed frames are never lost.
- Adds a pass-through mode: when ARQ is disabled, bytes commit on write.

Parameters:
- DATA_W, 8, payload word width in bits.
- DEPTH, 64, storage words. Must be a power of two and ≥ the largest frame payload.
- CNT_W, 8, width of the saturating drop and commit statistics counters.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_pyld_data  in  DATA_W  payload word from the demapper.
- i_pyld_valid  in  1  payload word valid.
- o_pyld_ready  out  1  buffer can accept a word.
- i_crc_err  in  1  CRC verdict for the current frame (1 = error).
- i_crc_err_valid  in  1  verdict strobe, one cycle per frame.
- i_arq_en  in  1  ARQ mode from the frame header.
- i_arq_en_valid  in  1  ARQ mode strobe.
- o_data  out  DATA_W  committed word to the UART TX.
- o_valid  out  1  committed word available.
- i_ready  in  1  UART TX accepts o_data.
- o_level  out  $clog2(DEPTH)+1  committed words not yet read.
- o_drop_cnt  out  CNT_W  frames discarded (saturating).
- o_commit_cnt  out  CNT_W  frames committed (saturating).
- o_overflow  out  1  sticky: the tentative region filled the whole buffer.

Behaviour:
- Storage:
  - DEPTH x DATA_W array.
  - Three pointers of $clog2(DEPTH)+1 bits each: wr_ptr (tentative), cm_ptr (commit), rd_ptr (read).
  - Pointers wrap naturally; the MSB distinguishes full from empty.
- Reset (async assert, sync release):
  - wr_ptr = cm_ptr = rd_ptr = 0.
  - Latched arq_mode = 1.
  - Both counters = 0; o_overflow = 0.
  - o_valid = 0, o_level = 0.
  - o_pyld_ready = 0 while i_rst is high, 1 afterwards.
- Write handshake:
  - A word is accepted when i_pyld_valid && o_pyld_ready.
  - It is stored at wr_ptr; wr_ptr increments.
  - o_pyld_ready = (wr_ptr - rd_ptr) != DEPTH.
- ARQ mode latch: on i_arq_en_valid, arq_mode <= i_arq_en. The new value takes effect for the next cycle's decisions.
- Pass-through (arq_mode = 0):
  - Every accepted word commits in the same edge: cm_ptr <= wr_ptr + 1.
  - Verdict strobes in this mode only increment o_commit_cnt (regardless of i_crc_err).
- ARQ mode (arq_mode = 1), on i_crc_err_valid:
  - i_crc_err = 0: cm_ptr <= wr_ptr (words written strictly before the strobe cycle); o_commit_cnt++.
  - i_crc_err = 1: wr_ptr <= cm_ptr (discard the tentative words); o_drop_cnt++.
- Verdict and write in the same cycle: the word written in the verdict cycle belongs to the NEXT frame.
  - Good verdict: cm_ptr <= old wr_ptr; wr_ptr <= old wr_ptr + 1.
  - Bad verdict: the word is stored at old cm_ptr; wr_ptr <= cm_ptr + 1.
- Read side (first-word fall-through):
  - o_valid = (cm_ptr != rd_ptr).
  - o_data = mem[rd_ptr], asynchronous read.
  - On o_valid && i_ready: rd_ptr increments.
  - A word committed at edge N is visible on o_valid in the cycle after edge N.
- o_level = cm_ptr - rd_ptr. Tentative words are never visible and never counted in o_level.
- Overflow:
  - If (wr_ptr - cm_ptr) == DEPTH, set o_overflow. It stays set until reset.
  - While full, o_pyld_ready stays low (backpressure only); the verdict still commits or discards normally.
- A verdict strobe with no tentative words is legal. A good verdict changes no pointer; a bad one changes no pointer. The counters still increment.
- Counters saturate at 2^CNT_W - 1.
- Reset mid-frame: all tentative and committed data are discarded and pointers return to 0.

Test Plan:
- ARQ on, write 10 words 0x00..0x09, good verdict, i_ready = 1 → o_valid rises in the cycle after the verdict edge; 0x00..0x09 read in order; o_commit_cnt = 1; o_level returns to 0.
- ARQ on: frame A (5 words) good; frame B (7 words) bad → only A's 5 words emerge; o_level peaks at 5; o_drop_cnt = 1; wr_ptr equals cm_ptr after B.
- Bad verdict in the same cycle as a write of 0xAA → all previous tentative words dropped; 0xAA survives; a following good verdict emits 0xAA only.
- arq_en_valid with arq_en = 0, then write 3 words with i_ready = 1 → each word appears on o_valid the cycle after acceptance; a bad verdict does not remove them.
- DEPTH = 16, i_ready = 0, write 16 words with no verdict → o_pyld_ready low after the 16th word; o_overflow = 1. A bad verdict then sets o_level = 0 and o_pyld_ready = 1.
- Assert i_rst asynchronously mid-frame with 3 committed words pending → o_valid = 0, o_level = 0, counters 0 immediately; o_pyld_ready = 1 after release.

Source files
------------

// File: rtl/rx_commit_fifo.sv
// rtl/rx_commit_fifo.sv - payload buffer that exposes a frame only after its CRC verdict
module rx_commit_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [DATA_W-1:0]          i_pyld_data,
    input  logic                       i_pyld_valid,
    output logic                       o_pyld_ready,
    input  logic                       i_crc_err,
    input  logic                       i_crc_err_valid,
    input  logic                       i_arq_en,
    input  logic                       i_arq_en_valid,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [CNT_W-1:0]           o_drop_cnt,
    output logic [CNT_W-1:0]           o_commit_cnt,
    output logic                       o_overflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // wr_ptr runs ahead with tentative words, cm_ptr marks the verified
    // boundary, rd_ptr trails behind the UART. rd <= cm <= wr at all times.
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  cm_ptr_q, cm_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              arq_mode_q, arq_mode_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  commit_cnt_q, commit_cnt_d;
    logic              overflow_q, overflow_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              rd_fire;
    logic              verdict_good;
    logic              verdict_bad;
    logic              verdict_any;
    logic [PTR_W-1:0]  wr_base;

    // Handshakes, verdict decoding and next-state for pointers, counters and flags
    always_comb begin
        o_pyld_ready = ~i_rst && ((wr_ptr_q - rd_ptr_q) != PTR_FULL);
        o_valid      = (cm_ptr_q != rd_ptr_q);
        o_data       = mem_q[rd_ptr_q[ADDR_W-1:0]];
        o_level      = cm_ptr_q - rd_ptr_q;
        o_drop_cnt   = drop_cnt_q;
        o_commit_cnt = commit_cnt_q;
        o_overflow   = overflow_q;

        accept       = i_pyld_valid && o_pyld_ready;
        rd_fire      = o_valid && i_ready;
        verdict_any  = i_crc_err_valid;
        verdict_good = arq_mode_q && i_crc_err_valid && !i_crc_err;
        verdict_bad  = arq_mode_q && i_crc_err_valid &&  i_crc_err;

        // A bad verdict rewinds the write pointer first, so a word arriving in
        // the same cycle lands where the discarded frame started and opens the
        // next frame.
        wr_base  = verdict_bad ? cm_ptr_q : wr_ptr_q;
        wr_ptr_d = accept ? (wr_base + PTR_ONE) : wr_base;

        // A good verdict commits only words written before this cycle; in
        // pass-through every accepted word (and any leftover tentative data)
        // commits on the same edge.
        cm_ptr_d = cm_ptr_q;
        if (verdict_good) begin
            cm_ptr_d = wr_ptr_q;
        end
        if (!arq_mode_q && accept) begin
            cm_ptr_d = wr_ptr_q + PTR_ONE;
        end

        rd_ptr_d = rd_fire ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        arq_mode_d = i_arq_en_valid ? i_arq_en : arq_mode_q;

        // Pass-through verdicts count as commits whatever the CRC said.
        commit_cnt_d = commit_cnt_q;
        if ((verdict_good || (!arq_mode_q && verdict_any)) && (commit_cnt_q != CNT_MAX)) begin
            commit_cnt_d = commit_cnt_q + CNT_ONE;
        end
        drop_cnt_d = drop_cnt_q;
        if (verdict_bad && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_ONE;
        end

        // Flag the edge on which the tentative region occupies every slot.
        overflow_d = overflow_q || ((wr_ptr_d - cm_ptr_d) == PTR_FULL);
    end

    // Control state with asynchronous reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q     <= '0;
            cm_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            arq_mode_q   <= 1'b1;
            drop_cnt_q   <= '0;
            commit_cnt_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            cm_ptr_q     <= cm_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            arq_mode_q   <= arq_mode_d;
            drop_cnt_q   <= drop_cnt_d;
            commit_cnt_q <= commit_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    // Payload storage; contents need no reset because pointers gate visibility
    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem_q[wr_base[ADDR_W-1:0]] <= i_pyld_data;
        end
    end

endmodule

// File: tb/tb_rx_commit_fifo.sv
// tb/tb_rx_commit_fifo.sv - scoreboard bench for rx_commit_fifo
module tb_rx_commit_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] i_pyld_data = '0;
    logic              i_pyld_valid = 1'b0;
    logic              o_pyld_ready;
    logic              i_crc_err = 1'b0;
    logic              i_crc_err_valid = 1'b0;
    logic              i_arq_en = 1'b0;
    logic              i_arq_en_valid = 1'b0;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic [$clog2(DEPTH):0] o_level;
    logic [CNT_W-1:0]  o_drop_cnt;
    logic [CNT_W-1:0]  o_commit_cnt;
    logic              o_overflow;

    rx_commit_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_pyld_data     (i_pyld_data),
        .i_pyld_valid    (i_pyld_valid),
        .o_pyld_ready    (o_pyld_ready),
        .i_crc_err       (i_crc_err),
        .i_crc_err_valid (i_crc_err_valid),
        .i_arq_en        (i_arq_en),
        .i_arq_en_valid  (i_arq_en_valid),
        .o_data          (o_data),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_level         (o_level),
        .o_drop_cnt      (o_drop_cnt),
        .o_commit_cnt    (o_commit_cnt),
        .o_overflow      (o_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] tent[$];
    logic [DATA_W-1:0] expq[$];
    int   m_commit = 0;
    int   m_drop   = 0;
    logic m_arq    = 1'b1;
    logic m_ovf    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read side: compare visibility, level and popped data against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            chk("o_valid", {31'd0, o_valid}, {31'd0, expq.size() != 0});
            chk("o_level", 32'(o_level), 32'(expq.size()));
            if (o_valid && i_ready && expq.size() != 0) begin
                chk("o_data", 32'(o_data), 32'(expq.pop_front()));
            end
        end
    end

    task automatic commit_tent();
        while (tent.size() != 0) expq.push_back(tent.pop_front());
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic cv, input logic ce,
                        input logic av, input logic ae);
        logic exp_ready;
        logic acc;
        i_pyld_valid    = v;
        i_pyld_data     = d;
        i_crc_err_valid = cv;
        i_crc_err       = ce;
        i_arq_en_valid  = av;
        i_arq_en        = ae;
        exp_ready = (tent.size() + expq.size()) != DEPTH;
        chk("o_pyld_ready", {31'd0, o_pyld_ready}, {31'd0, exp_ready});
        acc = v && exp_ready;
        @(posedge clk);
        if (cv) begin
            if (!m_arq) begin
                if (m_commit < 255) m_commit++;
            end else if (!ce) begin
                commit_tent();
                if (m_commit < 255) m_commit++;
            end else begin
                tent.delete();
                if (m_drop < 255) m_drop++;
            end
        end
        if (acc) begin
            if (m_arq) tent.push_back(d);
            else begin
                commit_tent();
                expq.push_back(d);
            end
        end
        if (av) m_arq = ae;
        if (tent.size() == DEPTH) m_ovf = 1'b1;
        #1;
        i_pyld_valid    = 1'b0;
        i_crc_err_valid = 1'b0;
        i_crc_err       = 1'b0;
        i_arq_en_valid  = 1'b0;
        i_arq_en        = 1'b0;
        chk("o_commit_cnt", 32'(o_commit_cnt), 32'(m_commit));
        chk("o_drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
        chk("o_overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic write_words(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) step(1'b1, base + 8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", {31'd0, o_pyld_ready}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_commit", 32'(o_commit_cnt), 32'd0);
        chk("rst_drop", 32'(o_drop_cnt), 32'd0);
        chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, o_pyld_ready}, 32'd1);

        // Good frame of 10 words, drained straight away
        i_ready = 1'b1;
        write_words(8'h00, 10);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(12);

        // Frame A good, frame B bad
        i_ready = 1'b0;
        write_words(8'h10, 5);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        write_words(8'h20, 7);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("level_after_b", 32'(o_level), 32'd5);
        i_ready = 1'b1;
        idle(7);

        // Bad verdict coinciding with a write of 0xAA
        write_words(8'h30, 3);
        step(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Good verdict coinciding with a write: that word opens the next frame
        write_words(8'h38, 2);
        step(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);

        // Pass-through mode
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        write_words(8'h40, 3);
        idle(2);
        i_ready = 1'b0;
        write_words(8'h50, 3);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("pt_level", 32'(o_level), 32'd3);
        i_ready = 1'b1;
        idle(5);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

        // Fill the whole buffer with one tentative frame
        i_ready = 1'b0;
        write_words(8'h60, DEPTH);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_ovf", {31'd0, o_overflow}, 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("after_drop_ready", {31'd0, o_pyld_ready}, 32'd1);
        idle(2);

        // Verdicts with no tentative words
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Commit counter saturation
        for (int k = 0; k < 260; k++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("commit_sat", 32'(o_commit_cnt), 32'd255);

        // Asynchronous reset mid-frame with committed words pending
        write_words(8'h70, 3);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        write_words(8'h78, 2);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        tent.delete();
        expq.delete();
        m_commit = 0;
        m_drop   = 0;
        m_arq    = 1'b1;
        m_ovf    = 1'b0;
        chk("arst_valid", {31'd0, o_valid}, 32'd0);
        chk("arst_level", 32'(o_level), 32'd0);
        chk("arst_commit", 32'(o_commit_cnt), 32'd0);
        chk("arst_drop", 32'(o_drop_cnt), 32'd0);
        chk("arst_ovf", {31'd0, o_overflow}, 32'd0);
        chk("arst_ready", {31'd0, o_pyld_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rel_ready", {31'd0, o_pyld_ready}, 32'd1);

        // Short frame after reset
        i_ready = 1'b1;
        write_words(8'h90, 2);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        chk("drained", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
